pipe_stage_skid: RTL

- Parametrised successor to the single-register pipeline latch (flush / load / hold).
- Two-entry skid-buffered pipeline stage with a valid/ready handshake on both sides, synchronous flush, and a saturating stall-cycle counter.
- Sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Lets the downstream stage stall without a combinational ready path back to upstream.

---
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with valid/ready handshakes on
// both sides, synchronous flush and a saturating stall-cycle counter.
// in_ready and out_valid decode only the state register, so downstream
// back-pressure never reaches upstream through combinational logic.
module pipe_stage_skid #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic [CNT_W-1:0] r_stall;

    logic             w_accept;
    logic             w_emit;
    logic             w_stalled;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Handshake decode; all flow-control outputs come straight from r_state.
    always_comb begin
        in_ready  = (r_state != ST_FULL);
        out_valid = (r_state != ST_EMPTY);
        occupancy = r_state;
        out_data  = r_head;
        stall_cnt = r_stall;
        w_accept  = in_valid & in_ready;
        w_emit    = out_valid & out_ready;
        w_stalled = out_valid & ~out_ready;
    end

    // Occupancy FSM and entry registers. The head is reloaded with FLUSH_VAL
    // whenever the stage drains, so out_data never shows a consumed word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_head  <= FLUSH_VAL;
            r_skid  <= FLUSH_VAL;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_head  <= FLUSH_VAL;
            r_skid  <= FLUSH_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head  <= in_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        r_head  <= in_data;
                    end else if (w_accept) begin
                        r_skid  <= in_data;
                        r_state <= ST_FULL;
                    end else if (w_emit) begin
                        r_head  <= FLUSH_VAL;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_emit) begin
                        r_head  <= r_skid;
                        r_skid  <= FLUSH_VAL;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_head  <= FLUSH_VAL;
                    r_skid  <= FLUSH_VAL;
                end
            endcase
        end
    end

    // Stall-cycle counter: clear wins, flush leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (stall_clr) begin
            r_stall <= '0;
        end else if (w_stalled) begin
            r_stall <= sat_inc(r_stall);
        end
    end

endmodule
